// File: rtl/mem_ctrl_if.sv
// Requester-side bundle of mem_ctrl: IF fetch port, MEM load/store port and stall requests.
// master = pipeline side driving requests, slave = mem_ctrl.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_len;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              stallreq_if;
  logic              stallreq_mem;

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_wr_en, mem_addr, mem_len, mem_wdata,
    input  if_done, if_inst, mem_done, mem_rdata, stallreq_if, stallreq_mem
  );

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_wr_en, mem_addr, mem_len, mem_wdata,
    output if_done, if_inst, mem_done, mem_rdata, stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM port between IF and MEM (MEM first, no pre-emption),
// serialising 1/2/4-byte accesses and assembling/splitting words little-endian.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic       mem_go, if_go;
  logic [2:0] mem_len_eff;
  logic [4:0] cap_sel;
  logic [4:0] wr_sel;

  assign mem_go      = bus.mem_req & ~mem_done_q;
  assign if_go       = bus.if_req & ~if_done_q & ~bus.if_flush;
  assign mem_len_eff = (bus.mem_len == 3'd1 || bus.mem_len == 3'd2) ? bus.mem_len : 3'd4;
  // byte cnt-1 in modulo-4 arithmetic: cnt=4 maps onto lane 3
  assign cap_sel     = {cnt_q[1:0] - 2'd1, 3'b000};
  assign wr_sel      = {cnt_q[1:0], 3'b000};

  assign bus.if_done      = if_done_q;
  assign bus.if_inst      = if_inst_q;
  assign bus.mem_done     = mem_done_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.stallreq_if  = bus.if_req & ~if_done_q;
  assign bus.stallreq_mem = bus.mem_req & ~mem_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_go) begin
          owner_d = OWN_MEM;
          base_d  = bus.mem_addr;
          len_d   = mem_len_eff;
          wdata_d = bus.mem_wdata;
          cnt_d   = '0;
          buf_d   = '0;
          state_d = bus.mem_wr_en ? WRITE : READ;
        end else if (if_go) begin
          owner_d = OWN_IF;
          base_d  = bus.if_addr;
          len_d   = 3'd4;
          cnt_d   = '0;
          buf_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (owner_q == OWN_IF && bus.if_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != 3'd0) buf_d[cap_sel +: 8] = ram_din;
          if (cnt_q == len_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (owner_q == OWN_MEM) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = buf_d;
            end else begin
              if_done_d = 1'b1;
              if_inst_d = buf_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      WRITE: begin
        if (cnt_q == len_q - 3'd1) begin
          state_d    = IDLE;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = '0;
    if (state_q == READ && cnt_q != len_q) begin
      ram_a = base_q + ADDR_W'(cnt_q);
    end else if (state_q == WRITE) begin
      ram_a    = base_q + ADDR_W'(cnt_q);
      ram_wr   = 1'b1;
      ram_dout = wdata_q[wr_sel +: 8];
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM with one-cycle read latency, a word-level
// memory model checked every cycle, and literal expectations for the key scenarios.
module tb_mem_ctrl;
  logic        clk;
  logic        rst;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] preload(input logic [9:0] i);
    case (i)
      10'h100: preload = 8'h13;
      10'h101, 10'h102, 10'h103: preload = 8'h00;
      10'h040: preload = 8'h34;
      10'h041: preload = 8'h12;
      10'h042: preload = 8'h78;
      10'h043: preload = 8'h56;
      default: preload = (i[7:0] + {i[9:8], 6'b0}) ^ 8'hA5;
    endcase
  endfunction

  function automatic int unsigned len_eff(input logic [2:0] l);
    return (l == 3'd1 || l == 3'd2) ? int'(l) : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Bench RAM: data presented on ram_din the cycle after the address.
  bit [7:0] ram [1024];
  bit       ram_wrote [1024];
  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_a[9:0]]       <= ram_dout;
      ram_wrote[ram_a[9:0]] <= 1'b1;
    end
    ram_din <= ram_wrote[ram_a[9:0]] ? ram[ram_a[9:0]] : preload(ram_a[9:0]);
  end

  // Architectural memory model, updated only when a store completes.
  bit [7:0] mdl [1024];
  bit       mdl_wrote [1024];
  function automatic logic [31:0] mdl_word(input logic [31:0] a, input int unsigned n);
    logic [31:0] w;
    logic [31:0] ak;
    w = '0;
    for (int unsigned k = 0; k < n; k++) begin
      ak = a + k;
      w[8*k +: 8] = mdl_wrote[ak[9:0]] ? mdl[ak[9:0]] : preload(ak[9:0]);
    end
    return w;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wexp_t;
  wexp_t wq [$];

  logic [31:0] last_if;
  logic [31:0] last_mem;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_if_done", {31'b0, bus.if_done}, 32'd0);
      chk("rst_mem_done", {31'b0, bus.mem_done}, 32'd0);
      chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
      last_if  = '0;
      last_mem = '0;
    end else begin
      logic [31:0] exp;
      logic [31:0] ak;
      wexp_t e;
      chk("stall_if", {31'b0, bus.stallreq_if}, {31'b0, bus.if_req & ~bus.if_done});
      chk("stall_mem", {31'b0, bus.stallreq_mem}, {31'b0, bus.mem_req & ~bus.mem_done});
      chk("done_excl", {31'b0, bus.if_done & bus.mem_done}, 32'd0);
      chk("if_done_wo_req", {31'b0, bus.if_done & ~bus.if_req}, 32'd0);
      chk("mem_done_wo_req", {31'b0, bus.mem_done & ~bus.mem_req}, 32'd0);
      if (bus.if_done) begin
        exp = mdl_word(bus.if_addr, 4);
        chk("if_inst", bus.if_inst, exp);
        last_if = exp;
      end else begin
        chk("if_inst_hold", bus.if_inst, last_if);
      end
      if (bus.mem_done && !bus.mem_wr_en) begin
        exp = mdl_word(bus.mem_addr, len_eff(bus.mem_len));
        chk("mem_rdata", bus.mem_rdata, exp);
        last_mem = exp;
      end else begin
        chk("mem_rdata_hold", bus.mem_rdata, last_mem);
      end
      if (ram_wr) begin
        if (wq.size() == 0) begin
          chk("ram_wr_unexpected", {31'b0, ram_wr}, 32'd0);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", ram_a, e.a);
          chk("wr_data", {24'b0, ram_dout}, {24'b0, e.d});
        end
      end
      if (bus.mem_done && bus.mem_wr_en) begin
        chk("store_bytes_left", wq.size(), 32'd0);
        for (int unsigned k = 0; k < len_eff(bus.mem_len); k++) begin
          ak = bus.mem_addr + k;
          mdl[ak[9:0]]       = bus.mem_wdata[8*k +: 8];
          mdl_wrote[ak[9:0]] = 1'b1;
        end
      end
    end
  end

  task automatic push_store(input logic [31:0] addr, input logic [2:0] len, input logic [31:0] wd);
    for (int unsigned k = 0; k < len_eff(len); k++) wq.push_back('{addr + k, wd[8*k +: 8]});
  endtask

  task automatic do_mem(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                        input logic [31:0] wd, input logic flush, input int exp_lat,
                        output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    bus.mem_req   = 1'b1;
    bus.mem_wr_en = wr;
    bus.mem_addr  = addr;
    bus.mem_len   = len;
    bus.mem_wdata = wd;
    bus.if_flush  = flush;
    if (wr) push_store(addr, len, wd);
    @(posedge clk); #1;
    n = 0;
    while (!bus.mem_done && n < 20) begin
      if (!wr && n < int'(len_eff(len))) begin
        chk("mem_rd_addr", ram_a, addr + n);
        chk("mem_rd_nowr", {31'b0, ram_wr}, 32'd0);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("mem_latency", n, exp_lat);
    rd = bus.mem_rdata;
    @(posedge clk); #1;
    bus.mem_req  = 1'b0;
    bus.if_flush = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] addr, input int exp_lat, output logic [31:0] inst);
    int n;
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    @(posedge clk); #1;
    n = 0;
    while (!bus.if_done && n < 20) begin
      if (n < 4) chk("if_rd_addr", ram_a, addr + n);
      @(posedge clk); #1;
      n++;
    end
    chk("if_latency", n, exp_lat);
    inst = bus.if_inst;
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int n, nm, ni;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_len   = '0;
    bus.mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_if_inst", bus.if_inst, 32'h0);
    chk("reset_mem_rdata", bus.mem_rdata, 32'h0);
    chk("reset_ram_a", ram_a, 32'h0);
    chk("reset_ram_dout", {24'b0, ram_dout}, 32'h0);
    rst = 1'b0;

    do_if(32'h100, 5, rd);
    chk("fetch_0x100", rd, 32'h00000013);

    do_mem(1'b1, 32'h20, 3'd4, 32'hAABBCCDD, 1'b0, 4, rd);
    do_mem(1'b0, 32'h20, 3'd4, 32'h0, 1'b0, 5, rd);
    chk("load_back_0x20", rd, 32'hAABBCCDD);

    do_mem(1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 3, rd);
    chk("load_len2", rd, 32'h00001234);
    do_mem(1'b0, 32'h40, 3'd5, 32'h0, 1'b0, 5, rd);
    chk("load_len5", rd, 32'h56781234);
    do_mem(1'b0, 32'h100, 3'd0, 32'h0, 1'b0, 5, rd);
    chk("load_len0", rd, 32'h00000013);

    do_mem(1'b1, 32'h50, 3'd1, 32'hFFFFFF9E, 1'b0, 1, rd);
    do_mem(1'b0, 32'h50, 3'd1, 32'h0, 1'b1, 2, rd);
    chk("load_len1_flush_ignored", rd, 32'h0000009E);

    do_mem(1'b0, 32'hFFFF_FFFE, 3'd4, 32'h0, 1'b0, 5, rd);
    do_mem(1'b1, 32'hFFFF_FFFF, 3'd2, 32'h1234BEEF, 1'b0, 2, rd);
    do_mem(1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0, 1'b0, 3, rd);
    chk("wrap_store_load", rd, 32'h0000BEEF);

    // simultaneous requests: MEM load wins, IF granted on the edge ending mem_done
    @(posedge clk); #1;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h100;
    bus.mem_req   = 1'b1;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = 32'h40;
    bus.mem_len   = 3'd2;
    @(posedge clk); #1;
    n = 0; nm = -1; ni = -1;
    while (ni < 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (bus.mem_done) nm = n;
      if (nm >= 0 && n == nm + 1) begin
        bus.mem_req = 1'b0;
        chk("arb_if_first_addr", ram_a, 32'h100);
      end
      if (bus.if_done) ni = n;
    end
    chk("arb_mem_done_cycle", nm, 3);
    chk("arb_if_done_cycle", ni, 9);
    chk("arb_if_inst", bus.if_inst, 32'h00000013);
    @(posedge clk); #1;
    bus.if_req = 1'b0;

    // flush in cycle 2 of a fetch, then a fresh fetch elsewhere
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h200;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.if_flush = 1'b1;
    bus.if_req   = 1'b0;
    @(posedge clk); #1;
    chk("flush_no_done", {31'b0, bus.if_done}, 32'd0);
    bus.if_flush = 1'b0;
    do_if(32'h300, 5, rd);
    chk("fetch_after_flush", rd, mdl_word(32'h300, 4));

    // reset in the middle of a store, request held across it
    @(posedge clk); #1;
    bus.mem_req   = 1'b1;
    bus.mem_wr_en = 1'b1;
    bus.mem_addr  = 32'h80;
    bus.mem_len   = 3'd4;
    bus.mem_wdata = 32'h11223344;
    push_store(32'h80, 3'd4, 32'h11223344);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_ram_wr", {31'b0, ram_wr}, 32'd0);
    chk("rst_mid_mem_done", {31'b0, bus.mem_done}, 32'd0);
    wq.delete();
    push_store(32'h80, 3'd4, 32'h11223344);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_addr0", ram_a, 32'h80);
    n = 0;
    while (!bus.mem_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("restart_latency", n, 4);
    @(posedge clk); #1;
    bus.mem_req = 1'b0;
    do_mem(1'b0, 32'h80, 3'd4, 32'h0, 1'b0, 5, rd);
    chk("restart_load_back", rd, 32'h11223344);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
